// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Pops bytes from the show-ahead head of the decompressor output FIFO (one
//   per clock) and packs them little-endian into WORD_BYTES-wide words. Words
//   leave on a valid/ready interface. A flush drains the FIFO and then emits
//   the remaining partial word, or an empty terminator, tagged last.
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   fifo_data_in     FIFO head byte, valid while !fifo_empty_in
//   fifo_empty_in    FIFO empty flag
//   fifo_rd_en_out   pop request to the FIFO (combinational)
//   flush_in         one-cycle end-of-block pulse
//   word_out         packed word, byte 0 in bits [7:0]
//   byte_en_out      valid-byte mask for word_out
//   word_valid_out   output word valid
//   word_ready_in    downstream accepts the word when valid & ready
//   last_out         word is the final word of the block
//   busy_out         bytes held, word held or flush pending
//   byte_count_out   total bytes popped since reset (wraps)
module fifo_word_packer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              fifo_data_in,
    input  logic                    fifo_empty_in,
    output logic                    fifo_rd_en_out,
    input  logic                    flush_in,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic [WORD_BYTES-1:0]   byte_en_out,
    output logic                    word_valid_out,
    input  logic                    word_ready_in,
    output logic                    last_out,
    output logic                    busy_out,
    output logic [CNT_WIDTH-1:0]    byte_count_out
);

    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(WORD_BYTES - 1);

    // Registered state
    logic [WORD_W-1:0]     asm_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  flush_pend_q;
    logic                  slot_full_q;
    logic [WORD_W-1:0]     word_q;
    logic [WORD_BYTES-1:0] en_q;
    logic                  last_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    // Next-state values
    logic [WORD_W-1:0]     asm_d;
    logic [IDX_W-1:0]      idx_d;
    logic                  flush_pend_d;
    logic                  slot_full_d;
    logic [WORD_W-1:0]     word_d;
    logic [WORD_BYTES-1:0] en_d;
    logic                  last_d;
    logic                  busy_d;
    logic [CNT_WIDTH-1:0]  cnt_d;

    logic                  handshake;
    logic                  stall;
    logic                  pop;
    logic                  flush_done;
    logic [WORD_W-1:0]     asm_wr;
    logic [WORD_W-1:0]     flush_word;
    logic [WORD_BYTES-1:0] flush_en;

    // Final lane may only be popped when the slot is free or freeing this cycle
    assign handshake      = slot_full_q & word_ready_in;
    assign stall          = (idx_q == LAST_LANE) & slot_full_q & ~handshake;
    assign pop            = ~fifo_empty_in & ~stall & ~reset;
    assign fifo_rd_en_out = pop;

    // Flush completes only once the FIFO is drained and the slot can take a word
    assign flush_done = flush_pend_q & fifo_empty_in & ~pop & (~slot_full_q | handshake);

    // Lane write and flush masking
    always_comb begin
        asm_wr     = asm_q;
        flush_word = '0;
        flush_en   = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (IDX_W'(i) == idx_q) begin
                asm_wr[i*8 +: 8] = fifo_data_in;
            end
            if (IDX_W'(i) < idx_q) begin
                flush_en[i]          = 1'b1;
                flush_word[i*8 +: 8] = asm_q[i*8 +: 8];
            end
        end
    end

    // Next-state logic
    always_comb begin
        asm_d        = asm_q;
        idx_d        = idx_q;
        flush_pend_d = flush_pend_q | flush_in;
        slot_full_d  = slot_full_q;
        word_d       = word_q;
        en_d         = en_q;
        last_d       = last_q;
        cnt_d        = cnt_q;

        if (handshake) begin
            slot_full_d = 1'b0;
        end

        if (pop) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (idx_q == LAST_LANE) begin
                word_d      = asm_wr;
                en_d        = '1;
                last_d      = 1'b0;
                slot_full_d = 1'b1;
                asm_d       = '0;
                idx_d       = '0;
            end else begin
                asm_d = asm_wr;
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (flush_done) begin
            // idx_q == 0 yields the empty terminator (word 0, mask 0)
            word_d       = flush_word;
            en_d         = flush_en;
            last_d       = 1'b1;
            slot_full_d  = 1'b1;
            asm_d        = '0;
            idx_d        = '0;
            flush_pend_d = 1'b0;
        end

        busy_d = (idx_d != '0) | slot_full_d | flush_pend_d;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q        <= '0;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
            slot_full_q  <= 1'b0;
            word_q       <= '0;
            en_q         <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
            slot_full_q  <= slot_full_d;
            word_q       <= word_d;
            en_q         <= en_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign word_out       = word_q;
    assign byte_en_out    = en_q;
    assign word_valid_out = slot_full_q;
    assign last_out       = last_q;
    assign busy_out       = busy_q;
    assign byte_count_out = cnt_q;

    // Never pop an empty FIFO
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_rd_en_out && fifo_empty_in));

    // A presented word stays put until it is accepted
    a_valid_hold: assert property (@(posedge clk) disable iff (reset)
        (word_valid_out && !word_ready_in) |=>
        (word_valid_out && $stable(word_out) && $stable(byte_en_out) && $stable(last_out)));

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Directed bench for fifo_word_packer: a queue models the show-ahead FIFO,
//   accepted words are captured and compared against hand-computed values.
module tb_fifo_word_packer;

    localparam int unsigned WB = 4;
    localparam int unsigned CW = 32;

    logic          clk;
    logic          reset;
    logic [7:0]    fifo_data_in;
    logic          fifo_empty_in;
    logic          fifo_rd_en_out;
    logic          flush_in;
    logic [8*WB-1:0] word_out;
    logic [WB-1:0] byte_en_out;
    logic          word_valid_out;
    logic          word_ready_in;
    logic          last_out;
    logic          busy_out;
    logic [CW-1:0] byte_count_out;

    fifo_word_packer #(.WORD_BYTES(WB), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_data_in   (fifo_data_in),
        .fifo_empty_in  (fifo_empty_in),
        .fifo_rd_en_out (fifo_rd_en_out),
        .flush_in       (flush_in),
        .word_out       (word_out),
        .byte_en_out    (byte_en_out),
        .word_valid_out (word_valid_out),
        .word_ready_in  (word_ready_in),
        .last_out       (last_out),
        .busy_out       (busy_out),
        .byte_count_out (byte_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [7:0]    q[$];
    logic [31:0]   got_w[$];
    logic [3:0]    got_e[$];
    logic          got_l[$];
    bit            gate_empty = 1'b0;
    int            pops = 0;
    int            rd_hi = 0;
    int            under_viol = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int n, input logic [31:0] ew,
                              input logic [3:0] ee, input logic el);
        logic [31:0] w;
        logic [3:0]  e;
        logic        l;
        w = (n < got_w.size()) ? got_w[n] : 32'hDEAD_BEEF;
        e = (n < got_e.size()) ? got_e[n] : 4'hx;
        l = (n < got_l.size()) ? got_l[n] : 1'bx;
        check({tag, "_word"}, 64'(w), 64'(ew));
        check({tag, "_en"},   64'(e), 64'(ee));
        check({tag, "_last"}, 64'(l), 64'(el));
    endtask

    task automatic drive_fifo();
        fifo_empty_in = (q.size() == 0) || gate_empty;
        fifo_data_in  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic clear_capture();
        got_w.delete();
        got_e.delete();
        got_l.delete();
    endtask

    // One clock: sample handshakes before the edge, update the FIFO model after it
    task automatic tick();
        logic p;
        p = fifo_rd_en_out;
        if (p) rd_hi++;
        if (p && fifo_empty_in) under_viol++;
        if (word_valid_out && word_ready_in) begin
            got_w.push_back(word_out);
            got_e.push_back(byte_en_out);
            got_l.push_back(last_out);
        end
        @(posedge clk);
        #1;
        if (p && q.size() != 0) begin
            void'(q.pop_front());
            pops++;
        end
        drive_fifo();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush_in = 1'b0;
        word_ready_in = 1'b1;
        drive_fifo();
        tick();
        tick();

        // Reset state
        check("rst_valid", 64'(word_valid_out), 64'd0);
        check("rst_busy",  64'(busy_out),       64'd0);
        check("rst_cnt",   64'(byte_count_out), 64'd0);
        check("rst_word",  64'(word_out),       64'd0);

        // 1: bytes 01..08, ready=1; nothing popped while reset is high
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        drive_fifo();
        #1;
        check("rst_no_pop", 64'(fifo_rd_en_out), 64'd0);
        tick();
        check("rst_pops", 64'(pops), 64'd0);
        reset = 1'b0;
        #1;
        rd_hi = 0;
        pops = 0;
        clear_capture();
        repeat (4) tick();
        check("t1_latency_valid", 64'(word_valid_out), 64'd1);
        check("t1_latency_word",  64'(word_out),       64'h0403_0201);
        repeat (4) tick();
        check("t1_rd_consecutive", 64'(rd_hi), 64'd8);
        repeat (3) tick();
        check("t1_rd_total", 64'(rd_hi), 64'd8);
        check("t1_nwords", 64'(got_w.size()), 64'd2);
        check_word("t1_w0", 0, 32'h0403_0201, 4'hF, 1'b0);
        check_word("t1_w1", 1, 32'h0807_0605, 4'hF, 1'b0);
        check("t1_cnt",  64'(byte_count_out), 64'd8);
        check("t1_busy", 64'(busy_out),       64'd0);

        // 2: six bytes then flush -> full word plus 2-byte last word
        clear_capture();
        for (int i = 0; i < 6; i++) q.push_back(8'hAA + 8'(i));
        drive_fifo();
        #1;
        repeat (6) tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("t2_busy_pend", 64'(busy_out), 64'd1);
        repeat (3) tick();
        check("t2_nwords", 64'(got_w.size()), 64'd2);
        check_word("t2_w0", 0, 32'hADAC_ABAA, 4'hF, 1'b0);
        check_word("t2_w1", 1, 32'h0000_AFAE, 4'h3, 1'b1);
        check("t2_busy", 64'(busy_out),       64'd0);
        check("t2_cnt",  64'(byte_count_out), 64'd14);

        // 3: flush together with the final-lane pop -> full word, then empty terminator
        clear_capture();
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
        drive_fifo();
        #1;
        repeat (3) tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("t3_full_last", 64'(last_out), 64'd0);
        tick();
        check("t3_term_valid", 64'(word_valid_out), 64'd1);
        check("t3_term_last",  64'(last_out),       64'd1);
        repeat (2) tick();
        check("t3_nwords", 64'(got_w.size()), 64'd2);
        check_word("t3_w0", 0, 32'h4433_2211, 4'hF, 1'b0);
        check_word("t3_w1", 1, 32'h0000_0000, 4'h0, 1'b1);
        check("t3_busy", 64'(busy_out),       64'd0);
        check("t3_cnt",  64'(byte_count_out), 64'd18);

        // 4: backpressure with 12 bytes queued. The slot holds one word and the
        // assembly can fill lanes 0..2; the final lane waits for the slot.
        clear_capture();
        word_ready_in = 1'b0;
        for (int i = 0; i < 12; i++) q.push_back(8'h21 + 8'(i));
        drive_fifo();
        #1;
        pops = 0;
        repeat (10) tick();
        check("t4_pops_stalled", 64'(pops),           64'd7);
        check("t4_rd_en_low",    64'(fifo_rd_en_out), 64'd0);
        check("t4_hold_valid",   64'(word_valid_out), 64'd1);
        check("t4_hold_word",    64'(word_out),       64'h2423_2221);
        check("t4_hold_en",      64'(byte_en_out),    64'hF);
        word_ready_in = 1'b1;
        #1;
        repeat (12) tick();
        check("t4_nwords", 64'(got_w.size()), 64'd3);
        check_word("t4_w0", 0, 32'h2423_2221, 4'hF, 1'b0);
        check_word("t4_w1", 1, 32'h2827_2625, 4'hF, 1'b0);
        check_word("t4_w2", 2, 32'h2C2B_2A29, 4'hF, 1'b0);
        check("t4_cnt",   64'(byte_count_out), 64'd30);
        check("t4_drain", 64'(q.size()),       64'd0);

        // 5: FIFO empty flag toggling every other cycle
        clear_capture();
        for (int i = 0; i < 6; i++) q.push_back(8'h31 + 8'(i));
        pops = 0;
        under_viol = 0;
        for (int i = 0; i < 14; i++) begin
            gate_empty = (i % 2) == 1;
            drive_fifo();
            #1;
            tick();
        end
        gate_empty = 1'b0;
        drive_fifo();
        #1;
        check("t5_pops",      64'(pops),           64'd6);
        check("t5_no_underf", 64'(under_viol),     64'd0);
        check("t5_cnt",       64'(byte_count_out), 64'd36);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        repeat (3) tick();
        check("t5_nwords", 64'(got_w.size()), 64'd2);
        check_word("t5_w0", 0, 32'h3433_3231, 4'hF, 1'b0);
        check_word("t5_w1", 1, 32'h0000_3635, 4'h3, 1'b1);

        // 6: reset with idx==3, slot full and flush pending
        clear_capture();
        word_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) q.push_back(8'h41 + 8'(i));
        drive_fifo();
        #1;
        pops = 0;
        repeat (10) tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("t6_pre_pops", 64'(pops),     64'd7);
        check("t6_pre_busy", 64'(busy_out), 64'd1);
        reset = 1'b1;
        #1;
        tick();
        check("t6_rst_valid", 64'(word_valid_out), 64'd0);
        check("t6_rst_busy",  64'(busy_out),       64'd0);
        check("t6_rst_cnt",   64'(byte_count_out), 64'd0);
        check("t6_rst_word",  64'(word_out),       64'd0);
        check("t6_rst_en",    64'(byte_en_out),    64'd0);
        check("t6_rst_last",  64'(last_out),       64'd0);
        check("t6_rst_rd",    64'(fifo_rd_en_out), 64'd0);
        reset = 1'b0;
        word_ready_in = 1'b1;
        q.push_back(8'h51); q.push_back(8'h52); q.push_back(8'h53);
        drive_fifo();
        #1;
        repeat (8) tick();
        check("t6_nwords", 64'(got_w.size()), 64'd1);
        check_word("t6_w0", 0, 32'h5352_5148, 4'hF, 1'b0);
        check("t6_cnt",  64'(byte_count_out), 64'd4);
        check("t6_busy", 64'(busy_out),       64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
